// File: rtl/cordic_angle_ctrl_if.sv
// Request/response handshake bundle between a client and the CORDIC angle controller.
// The master issues angles and consumes cos/sin; the slave is the controller.
interface cordic_angle_ctrl_if #(
  parameter int unsigned Width = 16
) ();
  logic             req_valid;
  logic             req_ready;
  logic [Width-1:0] angle;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [Width-1:0] cos;
  logic [Width-1:0] sin;
  logic             err;

  modport master (
    output req_valid, angle, rsp_ready,
    input  req_ready, rsp_valid, cos, sin, err
  );

  modport slave (
    input  req_valid, angle, rsp_ready,
    output req_ready, rsp_valid, cos, sin, err
  );
endinterface

// File: rtl/cordic_angle_ctrl.sv
// Folds a full-circle angle into the CORDIC core's half-circle range, runs the core once,
// and un-folds the result into a held cos/sin response (or an error on range/timeout).
module cordic_angle_ctrl #(
  parameter int unsigned Width      = 16,
  parameter int unsigned FracBits   = 13,
  parameter int          XInit      = 4975,
  parameter int          HalfPi     = 12868,
  parameter int          Pi         = 25736,
  parameter int unsigned TimeoutCyc = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cordic_angle_ctrl_if.slave bus,
  output logic             start_cordic_o,
  output logic [Width-1:0] x0_o,
  output logic [Width-1:0] y0_o,
  output logic [Width-1:0] z0_o,
  input  logic [Width-1:0] xn_i,
  input  logic [Width-1:0] yn_i,
  input  logic             done_tick_cordic_i
);

  if (FracBits >= Width || TimeoutCyc < 2) begin : g_bad_cfg
    $error("cordic_angle_ctrl: FracBits must be < Width and TimeoutCyc >= 2");
  end

  typedef enum logic [1:0] {StIdle, StStart, StWait, StHold} state_e;

  localparam int unsigned CntW = $clog2(TimeoutCyc);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCyc - 1);
  localparam logic signed [Width+1:0] PiE     = (Width+2)'(Pi);
  localparam logic signed [Width+1:0] HalfPiE = (Width+2)'(HalfPi);
  localparam logic [Width-1:0] PiW    = Width'(Pi);
  localparam logic [Width-1:0] XInitW = Width'(XInit);
  localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};
  localparam logic [Width-1:0] MaxPos = {1'b0, {(Width-1){1'b1}}};

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [Width-1:0] x0_q, x0_d, y0_q, y0_d, z0_q, z0_d;
  logic [Width-1:0] cos_q, cos_d, sin_q, sin_d;
  logic             err_q, err_d;

  logic signed [Width+1:0] ang_ext;
  logic [Width-1:0]        z_fold;
  logic                    fold_neg, out_of_range;

  function automatic logic [Width-1:0] neg_sat(input logic [Width-1:0] v);
    return (v == MinNeg) ? MaxPos : Width'(-v);
  endfunction

  // Wrap-around add/sub in Width bits is exact whenever the angle is within +/-Pi.
  always_comb begin
    ang_ext      = (Width+2)'(signed'(bus.angle));
    out_of_range = (ang_ext > PiE) || (ang_ext < -PiE);
    fold_neg     = 1'b1;
    if (ang_ext > HalfPiE) begin
      z_fold = bus.angle - PiW;
    end else if (ang_ext < -HalfPiE) begin
      z_fold = bus.angle + PiW;
    end else begin
      z_fold   = bus.angle;
      fold_neg = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    z0_d    = z0_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          x0_d  = XInitW;
          y0_d  = '0;
          z0_d  = z_fold;
          neg_d = fold_neg;
          if (out_of_range) begin
            err_d   = 1'b1;
            cos_d   = '0;
            sin_d   = '0;
            state_d = StHold;
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A done tick in the final counted cycle still beats the timeout.
        if (done_tick_cordic_i) begin
          cos_d   = neg_q ? neg_sat(xn_i) : xn_i;
          sin_d   = neg_q ? neg_sat(yn_i) : yn_i;
          err_d   = 1'b0;
          state_d = StHold;
        end else if (cnt_q == CntLast) begin
          cos_d   = '0;
          sin_d   = '0;
          err_d   = 1'b1;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      z0_q    <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      z0_q    <= z0_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StHold);
  assign bus.cos        = cos_q;
  assign bus.sin        = sin_q;
  assign bus.err        = err_q;
  assign start_cordic_o = (state_q == StStart);
  assign x0_o           = x0_q;
  assign y0_o           = y0_q;
  assign z0_o           = z0_q;

endmodule

// File: tb/tb_cordic_angle_ctrl.sv
// Directed bench for cordic_angle_ctrl with a scripted core responder and a
// transaction-level model that predicts every response and protocol signal per cycle.
module tb_cordic_angle_ctrl;

  localparam int W     = 16;
  localparam int SCALE = 8192;
  localparam int PI_Q  = int'(3.14159265358979 * SCALE);
  localparam int HPI_Q = int'(3.14159265358979 / 2.0 * SCALE);
  localparam int XI_Q  = int'(0.6072529 * SCALE);
  localparam int TMO   = 64;
  localparam int NOZ   = 999999;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start;
  logic [W-1:0]  x0, y0, z0;
  logic [W-1:0]  xn = '0, yn = '0;
  logic          done = 1'b0;

  cordic_angle_ctrl_if #(.Width(W)) bus ();

  cordic_angle_ctrl dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .bus                (bus),
    .start_cordic_o     (start),
    .x0_o               (x0),
    .y0_o               (y0),
    .z0_o               (z0),
    .xn_i               (xn),
    .yn_i               (yn),
    .done_tick_cordic_i (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat_neg(input int v);
    int r;
    r = -v;
    if (r > 32767) r = 32767;
    return r;
  endfunction

  function automatic int s(input logic [W-1:0] v);
    return int'(signed'(v));
  endfunction

  // Transaction model: one outstanding op, response cycle and payload predicted from rules.
  int cyc = 0;
  bit busy = 0, in_rng = 0, m_neg = 0;
  int start_at = 0, rsp_at = 0;
  int m_z0 = 0, m_cos = 0, m_sin = 0, m_err = 0;

  always @(posedge clk) begin
    int a;
    cyc++;
    if (rst) begin
      busy = 0;
    end else begin
      if (busy && bus.rsp_valid && bus.rsp_ready) begin
        busy = 0;
      end else if (busy && in_rng && done && (cyc - 1) > start_at && (cyc - 1) < rsp_at) begin
        rsp_at = cyc;
        m_cos  = m_neg ? sat_neg(s(xn)) : s(xn);
        m_sin  = m_neg ? sat_neg(s(yn)) : s(yn);
        m_err  = 0;
      end
      if (!busy && bus.req_valid && bus.req_ready) begin
        a        = s(bus.angle);
        busy     = 1;
        start_at = cyc;
        m_cos    = 0;
        m_sin    = 0;
        m_err    = 1;
        if (a > PI_Q || a < -PI_Q) begin
          in_rng = 0;
          rsp_at = cyc;
        end else begin
          in_rng = 1;
          rsp_at = cyc + TMO + 1;
          m_neg  = (a > HPI_Q) || (a < -HPI_Q);
          m_z0   = (a > HPI_Q) ? a - PI_Q : (a < -HPI_Q) ? a + PI_Q : a;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ev, es, ew;
    if (rst) begin
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_start", start, 0);
      chk("rst_cos", s(bus.cos), 0);
      chk("rst_err", bus.err, 0);
      chk("rst_z0", s(z0), 0);
    end else begin
      ev = busy && cyc >= rsp_at;
      es = busy && in_rng && cyc == start_at;
      ew = busy && in_rng && cyc >= start_at && cyc < rsp_at;
      chk("req_ready", bus.req_ready, !busy);
      chk("rsp_valid", bus.rsp_valid, ev);
      chk("start", start, es);
      if (ev) begin
        chk("cos", s(bus.cos), m_cos);
        chk("sin", s(bus.sin), m_sin);
        chk("err", bus.err, m_err);
      end
      if (ew) begin
        chk("x0", s(x0), XI_Q);
        chk("y0", s(y0), 0);
        chk("z0", s(z0), m_z0);
      end
    end
  end

  task automatic issue(input int ang);
    int i;
    for (i = 0; i < 200 && !bus.req_ready; i++) @(negedge clk);
    if (!bus.req_ready) chk("req_ready_wait", 0, 1);
    bus.req_valid = 1'b1;
    bus.angle     = W'(ang);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // lat < 0: core never ticks. Literal expectations pin the model independently.
  task automatic run_req(input int ang, input int lat, input int xv, input int yv,
                         input int rdy_dly, input bit late,
                         input int ez0, input int ecos, input int esin, input int eerr);
    bit got;
    issue(ang);
    @(negedge clk);
    if (ez0 != NOZ) chk("lit_z0", s(z0), ez0);
    if (lat >= 0) begin
      repeat (lat) @(posedge clk);
      #1;
      done = 1'b1;
      xn   = W'(xv);
      yn   = W'(yv);
      @(posedge clk);
      #1 done = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1;
        break;
      end
    end
    chk("rsp_arrives", got, 1);
    chk("lit_cos", s(bus.cos), ecos);
    chk("lit_sin", s(bus.sin), esin);
    chk("lit_err", bus.err, eerr);
    if (late) begin
      @(posedge clk);
      #1;
      done = 1'b1;
      xn   = W'(777);
      yn   = W'(-777);
      @(posedge clk);
      #1 done = 1'b0;
    end
    repeat (rdy_dly) @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.angle     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("lit_reset_req_ready", bus.req_ready, 1);
    chk("lit_reset_rsp_valid", bus.rsp_valid, 0);

    //      angle    lat  xn      yn     rdy late  z0      cos     sin    err
    run_req(0,       3,   8192,   0,     0,  0,    0,      8192,   0,     0);
    run_req(20000,   5,   5000,   -6000, 1,  0,    -5736,  -5000,  6000,  0);
    run_req(-20000,  2,   7000,   100,   0,  0,    5736,   -7000,  -100,  0);
    run_req(12868,   1,   1,      8192,  0,  0,    12868,  1,      8192,  0);
    run_req(-12868,  4,   -300,   -8000, 0,  0,    -12868, -300,   -8000, 0);
    run_req(25736,   2,   -8192,  5,     0,  0,    0,      8192,   -5,    0);
    run_req(30000,   -1,  0,      0,     2,  0,    NOZ,    0,      0,     1);
    run_req(-30000,  -1,  0,      0,     0,  0,    NOZ,    0,      0,     1);
    run_req(1000,    -1,  0,      0,     3,  1,    1000,   0,      0,     1);
    run_req(1000,    64,  4000,   -10,   0,  0,    1000,   4000,   -10,   0);
    run_req(-1000,   65,  4000,   -10,   0,  0,    -1000,  0,      0,     1);
    run_req(20000,   3,   -32768, 16,    10, 0,    -5736,  32767,  -16,   0);

    // Reset while waiting on the core; the tick that follows must be ignored.
    issue(100);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    done = 1'b1;
    xn   = W'(1234);
    yn   = W'(4321);
    @(posedge clk);
    #1 done = 1'b0;
    repeat (2) @(negedge clk);
    chk("lit_after_rst_req_ready", bus.req_ready, 1);
    chk("lit_after_rst_rsp_valid", bus.rsp_valid, 0);
    chk("lit_after_rst_cos", s(bus.cos), 0);

    run_req(-25000,  6,   2000,   3000,  0,  0,    736,    -2000,  -3000, 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
